alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, legal values 8..64.
REQ-002 SHALL have localparam SHW = clog2(WIDTH): shift-amount width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1: operands and op are presented.
REQ-006 SHALL have port in_ready  output  1: block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH: source 1.
REQ-008 SHALL have port b  input  WIDTH: source 2; b[SHW-1:0] is the shift amount for shifts.
REQ-009 SHALL have port alu_control  input  4: operation select.
REQ-010 SHALL have port out_valid  output  1: result, zero and overflow are valid.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-012 SHALL have port result  output  WIDTH: registered result.
REQ-013 SHALL have port zero  output  1: result == 0.
REQ-014 SHALL have port overflow  output  1: signed add/sub overflow, or nonzero multiply high half.

Function
REQ-015 SHALL decode alu_control: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 unsigned set-less-than, 0101 xor, 0110 nor, 0111 signed set-less-than, 1000 sll, 1001 srl, 1010 sra, 1011 unsigned multiply (low WIDTH bits), 1100-1111 add.
REQ-016 SHALL produce 1 for a true set-less-than and 0 otherwise, zero-extended to WIDTH.
REQ-017 SHALL implement add and sub modulo 2^WIDTH.
REQ-018 SHALL set overflow for add/sub on signed overflow, for multiply when product bits [2*WIDTH-1:WIDTH] are nonzero, and clear it for every other op.
REQ-019 SHALL use three FSM states: IDLE, MUL, DONE.
REQ-020 SHALL assert in_ready only in IDLE.
REQ-021 SHALL accept an operation on a cycle with in_valid && in_ready.
REQ-022 SHALL, for a non-multiply op, register result, zero and overflow at acceptance and move IDLE->DONE, so out_valid rises the cycle after acceptance.
REQ-023 SHALL, for a multiply, latch the operands at acceptance, move IDLE->MUL, and perform one shift-add step per cycle into a 2*WIDTH accumulator for exactly WIDTH cycles.
REQ-024 SHALL move MUL->DONE after the final step, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-025 SHALL assert out_valid only in DONE.
REQ-026 SHALL hold result, zero and overflow stable in DONE until out_valid && out_ready.
REQ-027 SHALL move DONE->IDLE on out_valid && out_ready; the earliest next acceptance is the following cycle.
REQ-028 SHALL derive zero from the registered result, valid whenever out_valid is 1.
REQ-029 SHALL ignore in_valid outside IDLE and SHALL NOT change in_ready combinationally from out_ready.
REQ-030 SHALL take the shift amount from b[SHW-1:0] only, ignoring the upper bits of b; sra SHALL replicate a[WIDTH-1].
REQ-031 SHALL make the set-less-than compare use the full WIDTH for both signed and unsigned variants.

Reset
REQ-032 SHALL, while reset is high, immediately force: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, overflow 0, and clear the accumulator and multiply step counter.
REQ-033 SHALL abort any in-flight multiply or pending DONE result on reset, with no output produced after reset deasserts.

Verification (WIDTH=16)
REQ-034 SHALL cover: add a=0x7FFF, b=0x0001 -> result 0x8000, overflow 1, zero 0, out_valid the cycle after acceptance.
REQ-035 SHALL cover: sub a=0x0005, b=0x0005 -> result 0x0000, zero 1, overflow 0; then sra a=0x8000, b=0x0013 (amount 3) -> result 0xF000.
REQ-036 SHALL cover: a=0xFFFF, b=0x0001; signed slt (0111) -> result 1; unsigned slt (0100) -> result 0.
REQ-037 SHALL cover: mul a=0x0100, b=0x0100 -> result 0x0000, zero 1, overflow 1; out_valid exactly 17 cycles after acceptance; in_ready 0 throughout.
REQ-038 SHALL cover: mul a=0x0003, b=0x0007 with out_ready held 0 for 3 cycles after out_valid -> result 0x0015 stable and in_ready 0; then out_ready 1 -> IDLE next cycle and a new add is accepted.
REQ-039 SHALL cover: reset pulse during MUL step 5 -> out_valid 0, in_ready 1, result 0 immediately; no spurious out_valid afterwards.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a one-cycle datapath for most operations and an
// iterative shift-add multiplier, wrapped in valid/ready handshakes on both sides.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpNor  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpMul  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     sum, diff, aluRes;
  logic                 aluOv;
  logic [SHW-1:0]       shamt;
  logic [2*WIDTH-1:0]   accStep;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];

  // Single-cycle operations; codes 0000 and 1100-1111 all fall through to add.
  always_comb begin
    aluRes = sum;
    aluOv  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    case (alu_control)
      OpSub: begin
        aluRes = diff;
        aluOv  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: begin
        aluRes = a & b;
        aluOv  = 1'b0;
      end
      OpOr: begin
        aluRes = a | b;
        aluOv  = 1'b0;
      end
      OpSltu: begin
        aluRes = {{(WIDTH-1){1'b0}}, (a < b)};
        aluOv  = 1'b0;
      end
      OpXor: begin
        aluRes = a ^ b;
        aluOv  = 1'b0;
      end
      OpNor: begin
        aluRes = ~(a | b);
        aluOv  = 1'b0;
      end
      OpSlt: begin
        aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        aluOv  = 1'b0;
      end
      OpSll: begin
        aluRes = a << shamt;
        aluOv  = 1'b0;
      end
      OpSrl: begin
        aluRes = a >> shamt;
        aluOv  = 1'b0;
      end
      OpSra: begin
        aluRes = $signed(a) >>> shamt;
        aluOv  = 1'b0;
      end
      default: ;
    endcase
  end

  assign accStep = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // The multiplicand walks left and the multiplier walks right, one bit per cycle.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_control == OpMul) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d   = aluRes;
            overflow_d = aluOv;
            state_d    = DONE;
          end
        end
      end
      MUL: begin
        acc_d    = accStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LastStep) begin
          result_d   = accStep[WIDTH-1:0];
          overflow_d = |accStep[2*WIDTH-1:WIDTH];
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      result_q   <= '0;
      overflow_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign zero      = (result_q == '0);

endmodule
